serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_ctrl.sv | 141 ++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_ctrl
// Description : Bit-serial WIDTH-bit adder, one shared full-adder cell, LSB first
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             w_ha0_s, w_ha0_c, w_ha1_c;
    logic             w_s_bit, w_carry_nxt;
    logic [WIDTH-1:0] w_result;

    // Full-adder cell: two half adders, carries merged by an OR
    assign w_ha0_s     = a_sh_q[0] ^ b_sh_q[0];
    assign w_ha0_c     = a_sh_q[0] & b_sh_q[0];
    assign w_s_bit     = w_ha0_s ^ carry_q;
    assign w_ha1_c     = w_ha0_s & carry_q;
    assign w_carry_nxt = w_ha0_c | w_ha1_c;

    // Partial-sum register keeps WIDTH-1 bits; the bit just computed completes the word
    generate
        if (WIDTH == 1) begin : g_single
            assign w_result = w_s_bit;
        end else begin : g_multi
            logic [WIDTH-2:0] s_sh_q, s_sh_d;

            assign w_result = {w_s_bit, s_sh_q};

            always_comb begin
                s_sh_d = s_sh_q;
                if (state_q == ST_IDLE && start_i) begin
                    s_sh_d = '0;
                end else if (state_q == ST_SHIFT) begin
                    s_sh_d = w_result[WIDTH-1:1];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s_sh_q <= '0;
                end else begin
                    s_sh_q <= s_sh_d;
                end
            end
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        carry_d  = carry_q;
        bitcnt_d = bitcnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    a_sh_d   = a_i;
                    b_sh_d   = b_i;
                    carry_d  = 1'b0;
                    bitcnt_d = '0;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                carry_d  = w_carry_nxt;
                bitcnt_d = bitcnt_q + CNT_W'(1);
                if (bitcnt_q == LAST_BIT) begin
                    sum_d   = w_result;
                    cout_d  = w_carry_nxt;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            carry_q  <= 1'b0;
            bitcnt_q <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            carry_q  <= carry_d;
            bitcnt_q <= bitcnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    assign busy_o = (state_q != ST_IDLE);
    assign done_o = (state_q == ST_DONE);
    assign sum_o  = sum_q;
    assign cout_o = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder_ctrl
// Description : Scoreboard bench for serial_adder_ctrl at WIDTH 8, 1 and 16
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        start8 = 1'b0, busy8, done8, cout8;
    logic [7:0]  a8 = '0, b8 = '0, sum8;
    logic        start1 = 1'b0, busy1, done1, cout1;
    logic [0:0]  a1 = '0, b1 = '0, sum1;
    logic        start16 = 1'b0, busy16, done16, cout16;
    logic [15:0] a16 = '0, b16 = '0, sum16;

    logic [8:0]  q8[$];
    logic [1:0]  q1[$];
    logic [16:0] q16[$];

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start_i(start8), .a_i(a8), .b_i(b8),
        .busy_o(busy8), .done_o(done8), .sum_o(sum8), .cout_o(cout8));
    serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start1), .a_i(a1), .b_i(b1),
        .busy_o(busy1), .done_o(done1), .sum_o(sum1), .cout_o(cout1));
    serial_adder_ctrl #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start_i(start16), .a_i(a16), .b_i(b16),
        .busy_o(busy16), .done_o(done16), .sum_o(sum16), .cout_o(cout16));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboards: every done pops the oldest expected {cout,sum}
    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) chk("done8_unexpected", 32'd1, 32'd0);
            else chk("result8", {23'd0, cout8, sum8}, {23'd0, q8.pop_front()});
        end
        if (done1) begin
            if (q1.size() == 0) chk("done1_unexpected", 32'd1, 32'd0);
            else chk("result1", {30'd0, cout1, sum1}, {30'd0, q1.pop_front()});
        end
        if (done16) begin
            if (q16.size() == 0) chk("done16_unexpected", 32'd1, 32'd0);
            else chk("result16", {15'd0, cout16, sum16}, {15'd0, q16.pop_front()});
        end
    end

    task automatic wait_idle8(output int dn);
        bit ok = 1'b0;
        dn = 0;
        for (int k = 0; k < 50; k++) begin
            if (done8) dn++;
            if (!busy8) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) chk("idle8_timeout", 32'd0, 32'd1);
    endtask

    // One full WIDTH=8 operation; the previous result must hold until done
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [8:0] hold_exp,
                        output int busy_n, output int done_n, output int lat, output bit hold_ok);
        int e0;
        busy_n = 0; done_n = 0; lat = -1; hold_ok = 1'b1;
        @(negedge clk);
        a8 = a; b8 = b; start8 = 1'b1;
        @(negedge clk);
        e0 = cyc;
        start8 = 1'b0;
        q8.push_back({1'b0, a} + {1'b0, b});
        for (int k = 0; k < 40; k++) begin
            if (!busy8) break;
            busy_n++;
            if (done8) begin
                done_n++;
                lat = cyc - e0;
            end else if (done_n == 0 && {cout8, sum8} !== hold_exp) begin
                hold_ok = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int  bn, dn, lat, nacc, last, dcount;
        bit  hok, pb, got, stray;

        // Reset state
        @(negedge clk);
        chk("rst_busy", {31'd0, busy8}, 32'd0);
        chk("rst_done", {31'd0, done8}, 32'd0);
        chk("rst_sum", {24'd0, sum8}, 32'd0);
        chk("rst_cout", {31'd0, cout8}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 0 + 0
        run8(8'h00, 8'h00, 9'h000, bn, dn, lat, hok);
        chk("zero_busy_cycles", bn, 32'd9);
        chk("zero_done_pulses", dn, 32'd1);
        chk("zero_latency", lat, 32'd8);

        // FF + 01 then A5 + 5A, previous result held
        run8(8'hFF, 8'h01, 9'h000, bn, dn, lat, hok);
        chk("ff01_latency", lat, 32'd8);
        chk("ff01_held_after", {23'd0, cout8, sum8}, 32'h100);
        run8(8'hA5, 8'h5A, 9'h100, bn, dn, lat, hok);
        chk("a55a_hold_until_done", {31'd0, hok}, 32'd1);
        chk("a55a_done_pulses", dn, 32'd1);

        // Continuous start: accepts every WIDTH+2 cycles
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
        pb = busy8; nacc = 0; last = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy8 && !pb) begin
                q8.push_back(9'h100);
                if (nacc > 0) chk("cont_spacing", cyc - last, 32'd10);
                last = cyc;
                nacc++;
            end
            pb = busy8;
        end
        start8 = 1'b0;
        wait_idle8(dn);
        chk("cont_accepts", nacc, 32'd4);
        chk("cont_queue_drained", q8.size(), 32'd0);

        // Operands change and start pulses mid-operation
        @(negedge clk);
        a8 = 8'h0F; b8 = 8'h01; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        q8.push_back(9'h010);
        a8 = 8'hFF; b8 = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_idle8(dn);
        chk("midstart_done_pulses", dn, 32'd1);
        stray = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (busy8) stray = 1'b1;
        end
        chk("midstart_not_queued", {31'd0, stray}, 32'd0);

        // Asynchronous reset mid-SHIFT
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy8}, 32'd0);
        chk("arst_done", {31'd0, done8}, 32'd0);
        chk("arst_sum", {24'd0, sum8}, 32'd0);
        chk("arst_cout", {31'd0, cout8}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        repeat (15) begin
            @(negedge clk);
            if (done8) dcount++;
        end
        chk("arst_no_done", dcount, 32'd0);
        run8(8'h12, 8'h34, 9'h000, bn, dn, lat, hok);
        chk("arst_after_latency", lat, 32'd8);
        chk("arst_after_done", dn, 32'd1);

        // Random WIDTH=1: start raised during DONE, accepted once IDLE
        pb = busy1; last = 0;
        for (int n = 0; n < 1000; n++) begin
            a1 = 1'($urandom); b1 = 1'($urandom); start1 = 1'b1;
            got = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (busy1 && !pb) begin got = 1'b1; pb = busy1; break; end
                pb = busy1;
            end
            if (!got) begin chk("w1_accept_timeout", 32'd0, 32'd1); break; end
            q1.push_back({1'b0, a1} + {1'b0, b1});
            if (n > 0) chk("w1_spacing_ge", {31'd0, (cyc - last) >= 3}, 32'd1);
            last = cyc;
            start1 = 1'b0;
            got = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                pb = busy1;
                if (done1) begin got = 1'b1; break; end
            end
            if (!got) begin chk("w1_done_timeout", 32'd0, 32'd1); break; end
        end
        start1 = 1'b0;

        // Random WIDTH=16
        @(negedge clk);
        pb = busy16; last = 0;
        for (int n = 0; n < 1000; n++) begin
            a16 = 16'($urandom); b16 = 16'($urandom); start16 = 1'b1;
            got = 1'b0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (busy16 && !pb) begin got = 1'b1; pb = busy16; break; end
                pb = busy16;
            end
            if (!got) begin chk("w16_accept_timeout", 32'd0, 32'd1); break; end
            q16.push_back({1'b0, a16} + {1'b0, b16});
            if (n > 0) chk("w16_spacing_ge", {31'd0, (cyc - last) >= 18}, 32'd1);
            last = cyc;
            start16 = 1'b0;
            got = 1'b0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                pb = busy16;
                if (done16) begin got = 1'b1; break; end
            end
            if (!got) begin chk("w16_done_timeout", 32'd0, 32'd1); break; end
        end
        start16 = 1'b0;

        repeat (4) @(negedge clk);
        chk("q8_empty", q8.size(), 32'd0);
        chk("q1_empty", q1.size(), 32'd0);
        chk("q16_empty", q16.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
